nco_phase_to_pdm: RTL and testbench



---
 rtl/nco_pkg.sv | 42 ++++
 rtl/nco_pdm_modulator.sv | 40 ++++
 rtl/nco_phase_to_pdm.sv | 76 +++++++
 tb/tb_nco_phase_to_pdm.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared constants and quarter-wave sine table for the micro-tile NCO datapath.
// The table is the single source of sine magnitudes for every consumer of the phase word.
package nco_pkg;

   localparam int PHASE_W   = 8;
   localparam int AMP_W     = 8;
   localparam int LUT_DEPTH = 64;
   localparam int IDX_W     = PHASE_W - 2;
   localparam int MAG_W     = AMP_W - 1;

   localparam logic [AMP_W-1:0] AMP_MID = 8'h80;

   // round(127*sin((i+0.5)*pi/128)): the half-step offset makes the quadrant
   // mirror exact, so folding with ~idx never duplicates the peak sample.
   localparam logic [MAG_W-1:0] QSINE_LUT [LUT_DEPTH] = '{
      7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
      7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
      7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
      7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
      7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
      7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
      7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
   };

   typedef struct packed {
      logic             vld;
      logic             sign;
      logic [IDX_W-1:0] idx;
   } fold_t;

   typedef struct packed {
      logic             vld;
      logic             sign;
      logic [MAG_W-1:0] mag;
   } mag_t;

   function automatic logic [MAG_W-1:0] quarter_sine(input logic [IDX_W-1:0] idx);
      return QSINE_LUT[idx];
   endfunction

endpackage

// File: rtl/nco_pdm_modulator.sv
// First-order sigma-delta: 8-bit accumulator whose carry (the 9th bit) is the PDM output.
// One cycle from amp_i to pdm_o; no backpressure, holds state while enable_i is low.
module nco_pdm_modulator #(
   parameter int AMP_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_i,
   input  logic [AMP_W-1:0] amp_i,
   output logic             pdm_o
);

   logic [AMP_W-1:0] acc_q, acc_d;
   logic             pdm_q, pdm_d;
   logic [AMP_W:0]   sum;

   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, amp_i};
      acc_d = acc_q;
      pdm_d = 1'b0;
      // Gated cycles freeze the residue so the bitstream resumes without a phase jump.
      if (enable_i) begin
         acc_d = sum[AMP_W-1:0];
         pdm_d = sum[AMP_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         pdm_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         pdm_q <= pdm_d;
      end
   end

   assign pdm_o = pdm_q;

endmodule

// File: rtl/nco_phase_to_pdm.sv
// Phase word -> folded quarter-wave LUT -> signed offset-binary amplitude -> PDM pin.
// Amplitude latency 3 cycles, PDM one more; one sample per clock, no backpressure.
module nco_phase_to_pdm #(
   parameter int PHASE_W   = 8,
   parameter int AMP_W     = 8,
   parameter int LUT_DEPTH = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PHASE_W-1:0] phase_i,
   input  logic               phase_valid_i,
   input  logic               enable_i,
   output logic [AMP_W-1:0]   amp_o,
   output logic               amp_valid_o,
   output logic               pdm_o
);

   import nco_pkg::*;

   localparam int IDX_BITS = $clog2(LUT_DEPTH);
   localparam logic [AMP_W-1:0] NEG_BASE = AMP_MID - AMP_W'(1);

   fold_t            s1_q, s1_d;
   mag_t             s2_q, s2_d;
   logic [AMP_W-1:0] amp_q, amp_d;
   logic             amp_vld_q, amp_vld_d;
   logic [IDX_BITS-1:0] idx_raw;

   assign idx_raw = phase_i[IDX_BITS-1:0];

   always_comb begin
      // Odd quadrants run the quarter wave backwards; the upper half is the sign.
      s1_d.vld  = phase_valid_i;
      s1_d.sign = phase_i[PHASE_W-1];
      s1_d.idx  = phase_i[PHASE_W-2] ? ~idx_raw : idx_raw;

      s2_d.vld  = s1_q.vld;
      s2_d.sign = s1_q.sign;
      s2_d.mag  = quarter_sine(s1_q.idx);

      amp_vld_d = s2_q.vld;
      amp_d     = amp_q;
      if (s2_q.vld) begin
         amp_d = s2_q.sign ? (NEG_BASE - {1'b0, s2_q.mag})
                           : (AMP_MID + {1'b0, s2_q.mag});
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         amp_q     <= AMP_MID;
         amp_vld_q <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         amp_q     <= amp_d;
         amp_vld_q <= amp_vld_d;
      end
   end

   assign amp_o       = amp_q;
   assign amp_valid_o = amp_vld_q;

   nco_pdm_modulator #(
      .AMP_W (AMP_W)
   ) u_mod (
      .clk      (clk),
      .rst      (rst),
      .enable_i (enable_i),
      .amp_i    (amp_q),
      .pdm_o    (pdm_o)
   );

endmodule

// File: tb/tb_nco_phase_to_pdm.sv
// Bench for nco_phase_to_pdm: amplitude reference from an ideal sine, modulator from running sums.
module tb_nco_phase_to_pdm;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] phase_i = 8'h00;
   logic       phase_valid_i = 1'b0;
   logic       enable_i = 1'b0;
   logic [7:0] amp_o;
   logic       amp_valid_o;
   logic       pdm_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   nco_phase_to_pdm #(
      .PHASE_W   (8),
      .AMP_W     (8),
      .LUT_DEPTH (64)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .phase_i       (phase_i),
      .phase_valid_i (phase_valid_i),
      .enable_i      (enable_i),
      .amp_o         (amp_o),
      .amp_valid_o   (amp_valid_o),
      .pdm_o         (pdm_o)
   );

   // Ideal sine sampled at mid-step: positive half rides above 128, negative half below 127.
   function automatic logic [7:0] exp_amp(input logic [7:0] p);
      real s;
      int  r;
      s = 127.0 * $sin((real'(p) + 0.5) * 3.141592653589793 / 128.0);
      if (s >= 0.0) r = 128 + $rtoi(s + 0.5);
      else          r = 127 - $rtoi(-s + 0.5);
      return 8'(r);
   endfunction

   // Cycle reference: fixed 3-cycle delay line for amplitudes, running-sum modulator.
   logic       m_vld [2];
   logic [7:0] m_pipe [2];
   logic [7:0] m_amp;
   logic       m_amp_vld;
   logic       m_pdm;
   int         m_acc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_vld[0]  <= 1'b0;
         m_vld[1]  <= 1'b0;
         m_amp     <= 8'h80;
         m_amp_vld <= 1'b0;
         m_pdm     <= 1'b0;
         m_acc     <= 0;
      end else begin
         if (enable_i) begin
            m_acc <= (m_acc + int'(m_amp)) % 256;
            m_pdm <= (m_acc + int'(m_amp)) >= 256;
         end else begin
            m_pdm <= 1'b0;
         end
         m_amp_vld <= m_vld[1];
         if (m_vld[1]) m_amp <= m_pipe[1];
         m_vld[1]  <= m_vld[0];
         m_pipe[1] <= m_pipe[0];
         m_vld[0]  <= phase_valid_i;
         m_pipe[0] <= exp_amp(phase_i);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      phase_valid_i = 1'b0;
      repeat (n) tick();
   endtask

   // Reset the modulator and park a steady amplitude with the accumulator still at zero.
   task automatic load_amp(input logic [7:0] p);
      enable_i = 1'b0;
      phase_valid_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      phase_i = p;
      phase_valid_i = 1'b1;
      tick();
      idle(3);
   endtask

   task automatic test_reset();
      enable_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         phase_i = 8'($urandom_range(0, 255));
         phase_valid_i = 1'b1;
         tick();
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (amp_o !== 8'h80) begin n_fail++; $display("FAIL reset_amp: got %0h expected 80", amp_o); end
      n_tests++;
      if (amp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %0b expected 0", amp_valid_o); end
      n_tests++;
      if (pdm_o !== 1'b0) begin n_fail++; $display("FAIL reset_pdm: got %0b expected 0", pdm_o); end
      n_tests++;
      if (dut.u_mod.acc_q !== 8'h00) begin n_fail++; $display("FAIL reset_acc: got %0h expected 0", dut.u_mod.acc_q); end
      phase_valid_i = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (amp_valid_o !== 1'b0 || amp_o !== 8'h80) begin
            n_fail++; $display("FAIL reset_idle: cycle %0d got vld=%0b amp=%0h expected vld=0 amp=80", i, amp_valid_o, amp_o);
         end
         n_tests++;
         if (pdm_o !== m_pdm) begin n_fail++; $display("FAIL reset_idle_pdm: cycle %0d got %0b expected %0b", i, pdm_o, m_pdm); end
      end
      phase_i = 8'h40;
      phase_valid_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         phase_valid_i = 1'b0;
         n_tests++;
         if (amp_valid_o !== (i == 3)) begin
            n_fail++; $display("FAIL reset_first_out: edge %0d got vld=%0b expected %0b", i, amp_valid_o, i == 3);
         end
      end
      n_tests++;
      if (amp_o !== 8'd255) begin n_fail++; $display("FAIL reset_first_amp: got %0d expected 255", amp_o); end
   endtask

   task automatic test_quadrants_and_wrap();
      logic [7:0] ph [8] = '{8'h00, 8'h3F, 8'h40, 8'h80, 8'hBF, 8'hC0, 8'hFF, 8'h00};
      logic [7:0] ex [8] = '{8'd130, 8'd255, 8'd255, 8'd125, 8'd0, 8'd0, 8'd125, 8'd130};
      idle(3);
      for (int i = 0; i < 10; i++) begin
         phase_valid_i = (i < 8);
         if (i < 8) phase_i = ph[i];
         tick();
         n_tests++;
         if (i < 2) begin
            if (amp_valid_o !== 1'b0) begin n_fail++; $display("FAIL quad_early_vld: tick %0d got %0b expected 0", i, amp_valid_o); end
         end else if (amp_valid_o !== 1'b1 || amp_o !== ex[i-2]) begin
            n_fail++; $display("FAIL quad_amp: phase %0h got vld=%0b amp=%0d expected vld=1 amp=%0d", ph[i-2], amp_valid_o, amp_o, ex[i-2]);
         end
      end
   endtask

   task automatic test_sweep();
      logic [7:0] got [256];
      idle(3);
      for (int i = 0; i < 258; i++) begin
         phase_valid_i = (i < 256);
         phase_i = 8'(i);
         tick();
         if (i >= 2) begin
            got[i-2] = amp_o;
            n_tests++;
            if (amp_valid_o !== 1'b1 || amp_o !== exp_amp(8'(i - 2))) begin
               n_fail++; $display("FAIL sweep_amp: phase %0h got vld=%0b amp=%0d expected vld=1 amp=%0d", i - 2, amp_valid_o, amp_o, exp_amp(8'(i - 2)));
            end
         end
      end
      for (int p = 0; p < 128; p++) begin
         n_tests++;
         if (int'(got[p]) + int'(got[p+128]) != 255) begin
            n_fail++; $display("FAIL sweep_symmetry: phase %0h sum %0d expected 255", p, int'(got[p]) + int'(got[p+128]));
         end
      end
   endtask

   task automatic test_valid_gaps();
      idle(3);
      phase_i = 8'h40;
      for (int i = 0; i < 12; i++) begin
         phase_valid_i = (i < 8) && (i % 2 == 0);
         tick();
         if (i >= 2) begin
            n_tests++;
            if (amp_valid_o !== ((i - 2) < 8 && (i - 2) % 2 == 0) || amp_o !== 8'd255) begin
               n_fail++; $display("FAIL gap_pattern: tick %0d got vld=%0b amp=%0d expected vld=%0b amp=255",
                                  i, amp_valid_o, amp_o, ((i - 2) < 8 && (i - 2) % 2 == 0));
            end
         end
      end
   endtask

   task automatic test_pdm_density();
      logic [7:0] ph   [3] = '{8'h00, 8'h3F, 8'hC0};
      logic [7:0] amp  [3] = '{8'h80, 8'hFF, 8'h00};
      int         want [3] = '{128, 255, 0};
      for (int s = 0; s < 3; s++) begin
         int ones = 0;
         if (s == 0) begin
            enable_i = 1'b0;
            phase_valid_i = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end else begin
            load_amp(ph[s]);
         end
         n_tests++;
         if (amp_o !== amp[s]) begin n_fail++; $display("FAIL density_amp: seg %0d got %0h expected %0h", s, amp_o, amp[s]); end
         enable_i = 1'b1;
         for (int k = 1; k <= 256; k++) begin
            tick();
            ones += int'(pdm_o);
            if (s == 0) begin
               n_tests++;
               if (pdm_o !== (k % 2 == 0)) begin n_fail++; $display("FAIL density_alternate: bit %0d got %0b expected %0b", k, pdm_o, k % 2 == 0); end
            end
         end
         n_tests++;
         if (ones != want[s]) begin n_fail++; $display("FAIL density_count: amp %0h got %0d ones expected %0d", amp[s], ones, want[s]); end
      end
   endtask

   task automatic test_enable_gating();
      logic [7:0] p;
      int a, k, eb, ea;
      p = 8'($urandom_range(1, 126));
      a = int'(exp_amp(p));
      load_amp(p);
      k = 0;
      for (int c = 0; c < 70; c++) begin
         enable_i = !(c >= 20 && c < 30);
         tick();
         if (enable_i) begin
            k++;
            eb = (k * a) / 256 - ((k - 1) * a) / 256;
         end else begin
            eb = 0;
         end
         ea = (k * a) % 256;
         n_tests++;
         if (pdm_o !== eb[0]) begin n_fail++; $display("FAIL gate_pdm: cycle %0d amp %0d got %0b expected %0b", c, a, pdm_o, eb[0]); end
         n_tests++;
         if (int'(dut.u_mod.acc_q) != ea) begin n_fail++; $display("FAIL gate_acc: cycle %0d got %0d expected %0d", c, dut.u_mod.acc_q, ea); end
      end
      enable_i = 1'b1;
   endtask

   task automatic test_back_to_back_random();
      for (int c = 0; c < 400; c++) begin
         phase_i       = 8'($urandom_range(0, 255));
         phase_valid_i = ($urandom_range(0, 3) != 0);
         enable_i      = ($urandom_range(0, 7) != 0);
         tick();
         n_tests++;
         if (amp_valid_o !== m_amp_vld || (m_amp_vld && amp_o !== m_amp)) begin
            n_fail++; $display("FAIL random_amp: cycle %0d got vld=%0b amp=%0d expected vld=%0b amp=%0d", c, amp_valid_o, amp_o, m_amp_vld, m_amp);
         end
         n_tests++;
         if (amp_o !== m_amp) begin n_fail++; $display("FAIL random_hold: cycle %0d got %0d expected %0d", c, amp_o, m_amp); end
         n_tests++;
         if (pdm_o !== m_pdm) begin n_fail++; $display("FAIL random_pdm: cycle %0d got %0b expected %0b", c, pdm_o, m_pdm); end
      end
   endtask

   initial begin
      #1 rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      test_reset();
      test_quadrants_and_wrap();
      test_sweep();
      test_valid_gaps();
      test_pdm_density();
      test_enable_gating();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      test_back_to_back_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
